// File: rtl/board_b_pixel_mixer.sv
// Final video mixer: tile/object priority, 512x15 palette lookup, blanked RGB out (3-cycle latency).
// Optional CPU palette readback is enabled with the PALETTE_READBACK_EN macro.
`timescale 1ns/1ps

module board_b_pixel_mixer #(
  parameter int unsigned PIPE_DLY = 3,
  parameter int unsigned PAL_AW   = 9
) (
  input  logic              DCLK,
  input  logic              reset,
  input  logic [3:0]        A_BIT,
  input  logic [3:0]        A_COL,
  input  logic [3:0]        B_BIT,
  input  logic [3:0]        B_COL,
  input  logic [3:0]        OBJ_BIT,
  input  logic [3:0]        OBJ_COL,
  input  logic              PRI_SEL,
  input  logic              HBLK,
  input  logic              VBLK,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [PAL_AW-1:0] CPU_ADDR,
  input  logic [14:0]       CPU_DIN,
  input  logic [1:0]        CPU_BYTE_SEL,
  output logic [14:0]       CPU_DOUT,
  output logic              CPU_ACK,
  output logic [4:0]        R,
  output logic [4:0]        G,
  output logic [4:0]        B,
  output logic              BLANK
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StAck    = 2'd2;

  logic [14:0]       pal_mem [0:(1<<PAL_AW)-1];

  logic [PAL_AW-1:0] idx_d, idx_q;
  logic [PIPE_DLY-2:0] blank_pipe_q;
  logic [14:0]       pal_rd_q;

  logic [1:0]        cpu_st_d, cpu_st_q;
  logic              req_prev_q;
  logic              cpu_we_q;
  logic [PAL_AW-1:0] cpu_addr_q;
  logic [14:0]       cpu_din_q;
  logic [1:0]        cpu_sel_q;
  logic              cpu_start;

  // Stage 1: priority resolve; layer B is backmost and never transparent.
  always_comb begin
    idx_d = {1'b0, B_COL, B_BIT};
    if (!PRI_SEL) begin
      if (OBJ_BIT != 4'd0)    idx_d = {1'b1, OBJ_COL, OBJ_BIT};
      else if (A_BIT != 4'd0) idx_d = {1'b0, A_COL, A_BIT};
    end else begin
      if (A_BIT != 4'd0)        idx_d = {1'b0, A_COL, A_BIT};
      else if (OBJ_BIT != 4'd0) idx_d = {1'b1, OBJ_COL, OBJ_BIT};
    end
  end

  // Blank flag rides alongside stages 1 and 2; reset holds the output blanked.
  always_ff @(posedge DCLK) begin
    if (reset) begin
      idx_q        <= '0;
      blank_pipe_q <= '1;
      pal_rd_q     <= '0;
      R            <= '0;
      G            <= '0;
      B            <= '0;
      BLANK        <= 1'b1;
    end else begin
      idx_q        <= idx_d;
      blank_pipe_q <= {blank_pipe_q[PIPE_DLY-3:0], HBLK | VBLK};
      pal_rd_q     <= pal_mem[idx_q];
      BLANK        <= blank_pipe_q[PIPE_DLY-2];
      if (blank_pipe_q[PIPE_DLY-2]) begin
        R <= '0;
        G <= '0;
        B <= '0;
      end else begin
        R <= pal_rd_q[14:10];
        G <= pal_rd_q[9:5];
        B <= pal_rd_q[4:0];
      end
    end
  end

  // CPU write port; nonblocking update gives the video port read-before-write.
  always_ff @(posedge DCLK) begin
    if (cpu_st_q == StAccess && cpu_we_q) begin
      if (cpu_sel_q[0]) pal_mem[cpu_addr_q][7:0]  <= cpu_din_q[7:0];
      if (cpu_sel_q[1]) pal_mem[cpu_addr_q][14:8] <= cpu_din_q[14:8];
    end
  end

  // A new access needs REQ seen low first, so a held REQ never retriggers.
  assign cpu_start = CPU_REQ && !req_prev_q;

  always_comb begin
    cpu_st_d = cpu_st_q;
    case (cpu_st_q)
      StIdle:   if (cpu_start) cpu_st_d = StAccess;
      StAccess: cpu_st_d = StAck;
      StAck:    if (!CPU_REQ) cpu_st_d = StIdle;
      default:  cpu_st_d = StIdle;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (reset) begin
      cpu_st_q   <= StIdle;
      req_prev_q <= 1'b1;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_sel_q  <= '0;
    end else begin
      cpu_st_q   <= cpu_st_d;
      req_prev_q <= CPU_REQ;
      if (cpu_st_q == StIdle && cpu_start) begin
        cpu_we_q   <= CPU_WE;
        cpu_addr_q <= CPU_ADDR;
        cpu_din_q  <= CPU_DIN;
        cpu_sel_q  <= CPU_BYTE_SEL;
      end
    end
  end

  assign CPU_ACK = (cpu_st_q == StAck);

`ifdef PALETTE_READBACK_EN
  logic [14:0] cpu_dout_q;
  logic [14:0] cpu_old;

  assign cpu_old = pal_mem[cpu_addr_q];

  // Writes report the post-merge word; reads report the stored word.
  always_ff @(posedge DCLK) begin
    if (reset) begin
      cpu_dout_q <= '0;
    end else if (cpu_st_q == StAccess) begin
      if (cpu_we_q) begin
        cpu_dout_q <= {cpu_sel_q[1] ? cpu_din_q[14:8] : cpu_old[14:8],
                       cpu_sel_q[0] ? cpu_din_q[7:0]  : cpu_old[7:0]};
      end else begin
        cpu_dout_q <= cpu_old;
      end
    end
  end

  assign CPU_DOUT = cpu_dout_q;
`else
  assign CPU_DOUT = '0;
`endif

endmodule

// File: tb/tb_board_b_pixel_mixer.sv
// Directed self-checking bench for board_b_pixel_mixer (honours PALETTE_READBACK_EN if defined).
`timescale 1ns/1ps

module tb_board_b_pixel_mixer;

  logic        DCLK = 1'b0;
  logic        reset;
  logic [3:0]  A_BIT, A_COL, B_BIT, B_COL, OBJ_BIT, OBJ_COL;
  logic        PRI_SEL, HBLK, VBLK;
  logic        CPU_REQ, CPU_WE;
  logic [8:0]  CPU_ADDR;
  logic [14:0] CPU_DIN;
  logic [1:0]  CPU_BYTE_SEL;
  logic [14:0] CPU_DOUT;
  logic        CPU_ACK;
  logic [4:0]  R, G, B;
  logic        BLANK;

  int tests = 0;
  int fails = 0;

  board_b_pixel_mixer dut (
    .DCLK         (DCLK),
    .reset        (reset),
    .A_BIT        (A_BIT),
    .A_COL        (A_COL),
    .B_BIT        (B_BIT),
    .B_COL        (B_COL),
    .OBJ_BIT      (OBJ_BIT),
    .OBJ_COL      (OBJ_COL),
    .PRI_SEL      (PRI_SEL),
    .HBLK         (HBLK),
    .VBLK         (VBLK),
    .CPU_REQ      (CPU_REQ),
    .CPU_WE       (CPU_WE),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_DIN      (CPU_DIN),
    .CPU_BYTE_SEL (CPU_BYTE_SEL),
    .CPU_DOUT     (CPU_DOUT),
    .CPU_ACK      (CPU_ACK),
    .R            (R),
    .G            (G),
    .B            (B),
    .BLANK        (BLANK)
  );

  always #5 DCLK = ~DCLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge DCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dout(input string tag, input logic [14:0] exp);
`ifdef PALETTE_READBACK_EN
    chk(tag, {1'b0, CPU_DOUT}, {1'b0, exp});
`else
    chk(tag, {1'b0, CPU_DOUT}, 16'h0000);
`endif
  endtask

  task automatic cpu_access(input logic we, input logic [8:0] a, input logic [14:0] d,
                            input logic [1:0] sel, input logic [14:0] exp_dout);
    CPU_REQ = 1'b1;
    CPU_WE = we;
    CPU_ADDR = a;
    CPU_DIN = d;
    CPU_BYTE_SEL = sel;
    step();
    chk("ack_wait", {15'd0, CPU_ACK}, 16'd0);
    step();
    chk("ack_rise", {15'd0, CPU_ACK}, 16'd1);
    chk_dout("cpu_dout", exp_dout);
    CPU_DIN = ~d;
    CPU_ADDR = ~a;
    step();
    chk("ack_hold", {15'd0, CPU_ACK}, 16'd1);
    chk_dout("dout_hold", exp_dout);
    CPU_REQ = 1'b0;
    step();
    chk("ack_drop", {15'd0, CPU_ACK}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    {A_BIT, A_COL, B_BIT, B_COL, OBJ_BIT, OBJ_COL} = '0;
    PRI_SEL = 1'b0;
    HBLK = 1'b1;
    VBLK = 1'b0;
    CPU_REQ = 1'b0;
    CPU_WE = 1'b0;
    CPU_ADDR = '0;
    CPU_DIN = '0;
    CPU_BYTE_SEL = '0;
    step(3);
    reset = 1'b0;
    chk("rst_rgb", {1'b0, R, G, B}, 16'h0000);
    chk("rst_blank", {15'd0, BLANK}, 16'd1);
    chk("rst_ack", {15'd0, CPU_ACK}, 16'd0);
    chk("rst_dout", {1'b0, CPU_DOUT}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_rgb", {1'b0, R, G, B}, 16'h0000);
      chk("idle_blank", {15'd0, BLANK}, 16'd1);
      chk("idle_ack", {15'd0, CPU_ACK}, 16'd0);
    end

    // Palette setup and readback.
    cpu_access(1'b1, 9'h1A5, 15'h7C1F, 2'b11, 15'h7C1F);
    cpu_access(1'b0, 9'h1A5, 15'h0000, 2'b00, 15'h7C1F);
    cpu_access(1'b1, 9'h0A3, 15'h03E0, 2'b11, 15'h03E0);
    cpu_access(1'b1, 9'h020, 15'h2A4A, 2'b11, 15'h2A4A);

    // Obj 0x1A5 over A 0x0A3; latency exactly 3 cycles.
    HBLK = 1'b0;
    PRI_SEL = 1'b0;
    OBJ_COL = 4'hA; OBJ_BIT = 4'h5;
    A_COL = 4'hA;   A_BIT = 4'h3;
    B_COL = 4'h2;   B_BIT = 4'h0;
    step(2);
    chk("lat_blank_early", {15'd0, BLANK}, 16'd1);
    step();
    chk("pri0_obj", {1'b0, R, G, B}, 16'h7C1F);
    chk("pri0_blank", {15'd0, BLANK}, 16'd0);

    PRI_SEL = 1'b1;
    step(2);
    chk("pri1_early", {1'b0, R, G, B}, 16'h7C1F);
    step();
    chk("pri1_a", {1'b0, R, G, B}, 16'h03E0);

    A_BIT = 4'h0;
    step(3);
    chk("pri1_obj", {1'b0, R, G, B}, 16'h7C1F);

    OBJ_BIT = 4'h0;
    PRI_SEL = 1'b0;
    step(3);
    chk("b_back", {1'b0, R, G, B}, 16'h2A4A);

    // Single-cycle HBLK pulse.
    HBLK = 1'b1;
    step();
    HBLK = 1'b0;
    step();
    chk("hblk_pre", {BLANK, R, G, B}, 16'h2A4A);
    step();
    chk("hblk_on", {BLANK, R, G, B}, 16'h8000);
    step();
    chk("hblk_post", {BLANK, R, G, B}, 16'h2A4A);

    VBLK = 1'b1;
    step(3);
    chk("vblk_on", {BLANK, R, G, B}, 16'h8000);
    VBLK = 1'b0;
    step(3);
    chk("vblk_off", {BLANK, R, G, B}, 16'h2A4A);

    // Low-byte write to 0x020 while video reads it: old pixel, then new.
    CPU_REQ = 1'b1;
    CPU_WE = 1'b1;
    CPU_ADDR = 9'h020;
    CPU_DIN = 15'h0155;
    CPU_BYTE_SEL = 2'b01;
    step();
    step();
    chk("rbw_ack", {15'd0, CPU_ACK}, 16'd1);
    chk("rbw_before", {1'b0, R, G, B}, 16'h2A4A);
    step();
    chk("rbw_old", {1'b0, R, G, B}, 16'h2A4A);
    step();
    chk("rbw_new", {1'b0, R, G, B}, 16'h2A55);
    chk_dout("rbw_dout", 15'h2A55);
    CPU_REQ = 1'b0;
    step();
    chk("rbw_ack_drop", {15'd0, CPU_ACK}, 16'd0);

    // Empty byte mask leaves RAM untouched.
    cpu_access(1'b1, 9'h020, 15'h7FFF, 2'b00, 15'h2A55);
    step(3);
    chk("sel00_keep", {1'b0, R, G, B}, 16'h2A55);

    // High byte only.
    cpu_access(1'b1, 9'h0A3, 15'h7FFF, 2'b10, 15'h7FE0);
    A_BIT = 4'h3;
    step(3);
    chk("sel10_merge", {1'b0, R, G, B}, 16'h7FE0);

    // Reset during ACCESS.
    CPU_REQ = 1'b1;
    CPU_WE = 1'b0;
    CPU_ADDR = 9'h1A5;
    step();
    reset = 1'b1;
    step();
    chk("midrst_ack", {15'd0, CPU_ACK}, 16'd0);
    chk("midrst_out", {BLANK, R, G, B}, 16'h8000);
    chk("midrst_dout", {1'b0, CPU_DOUT}, 16'h0000);
    reset = 1'b0;
    CPU_REQ = 1'b0;
    step(2);
    chk("postrst_ack", {15'd0, CPU_ACK}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_b_pixel_mixer.md
Name: board_b_pixel_mixer

Overview:
- Final video stage downstream of the tile-layer generators.
- Takes per-pixel outputs from both tile layers (4-bit pixel BIT + 4-bit palette COL) and the object layer, and resolves priority.
- Looks up a 512-entry x 15-bit palette RAM and emits registered RGB with blanking applied.
- CPU palette access uses a 4-phase req/ack handshake on the same pixel clock.

Parameters:
- PIPE_DLY, 3, pixel-in to RGB-out latency in DCLK cycles; fixed pipeline depth, only value supported is 3.
- PAL_AW, 9, palette address width (512 entries).

Ports:
- DCLK  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- A_BIT  in  4  layer A pixel; 0 = transparent.
- A_COL  in  4  layer A palette select.
- B_BIT  in  4  layer B pixel; never transparent (backmost).
- B_COL  in  4  layer B palette select.
- OBJ_BIT  in  4  object pixel; 0 = transparent.
- OBJ_COL  in  4  object palette select.
- PRI_SEL  in  1  0: OBJ > A > B; 1: A > OBJ > B.
- HBLK  in  1  horizontal blank, aligned with pixel inputs.
- VBLK  in  1  vertical blank, aligned with pixel inputs.
- CPU_REQ  in  1  palette access request (level, 4-phase).
- CPU_WE  in  1  1 = write, 0 = read; sampled with request.
- CPU_ADDR  in  9  palette entry.
- CPU_DIN  in  15  write data {R[4:0],G[4:0],B[4:0]}.
- CPU_BYTE_SEL  in  2  [0] writes bits 7:0, [1] writes bits 14:8.
- CPU_DOUT  out  15  read data, valid while CPU_ACK=1.
- CPU_ACK  out  1  handshake acknowledge.
- R  out  5  red.
- G  out  5  green.
- B  out  5  blue.
- BLANK  out  1  delayed composite blank (HBLK|VBLK).

Behaviour:
- Reset: R=G=B=0, BLANK=1, CPU_ACK=0, CPU_DOUT=0, all pipeline registers cleared, handshake FSM to IDLE. Palette contents not cleared.
- Stage 1 (priority), registered:
  - PRI_SEL=0: OBJ_BIT!=0 selects obj; else A_BIT!=0 selects A; else B.
  - PRI_SEL=1: A first, then OBJ, then B.
  - Index: obj = {1'b1,OBJ_COL,OBJ_BIT}; A = {1'b0,A_COL,A_BIT}; B = {1'b0,B_COL,B_BIT}.
  - Blank flag = HBLK|VBLK registered alongside.
- Stage 2: palette video-port read at the stage-1 index; synchronous RAM, data available next cycle.
- Stage 3: RGB <= blank ? 0 : palette data; BLANK <= blank.
- Total latency: exactly 3 DCLK from inputs to R/G/B/BLANK. Every cycle produces one output; no stall.
- Palette is true dual-port: video read port and CPU port both on DCLK.
- Same-address CPU write and video read in one cycle: video returns old data (read-before-write).
- CPU FSM states IDLE, ACCESS, ACK:
  - IDLE: CPU_REQ=1 latches CPU_WE/ADDR/DIN/BYTE_SEL -> ACCESS.
  - ACCESS (1 cycle): write with byte enables, or issue read -> ACK.
  - ACK: CPU_ACK=1; CPU_DOUT holds read data (write: holds written word post-merge). Stays until CPU_REQ=0 -> IDLE, CPU_ACK=0 the next cycle.
  - Inputs changing while not in IDLE are ignored.
  - REQ held high across ACK->IDLE does not retrigger; a new access requires REQ low for at least one cycle.
  - Request-to-ACK latency: 2 cycles.
- Reset asserted mid-access: FSM to IDLE, ACK drops next edge; an in-flight ACCESS write is not guaranteed to complete.
- Width rules: no arithmetic. BYTE_SEL=00 during a write: no RAM change, handshake still completes.

Optional Feature:
- Macro PALETTE_READBACK_EN.
- Defined: CPU reads return palette contents on CPU_DOUT as above.
- Undefined: CPU port is write-only in RAM terms. Reads still complete the full handshake with CPU_DOUT=0. CPU_DOUT is 0 after writes. The CPU read data path is removed.

Test Plan:
- Reset, then hold inputs 3 cycles -> R=G=B=0, BLANK=1 throughout; CPU_ACK=0.
- CPU write addr 0x1A5 = 0x7C1F, BYTE_SEL=11 -> ACK high exactly 2 cycles after REQ, holds until REQ falls, drops 1 cycle later. Readback (with PALETTE_READBACK_EN) returns 0x7C1F.
- Palette obj index 0x1A5 = 0x7C1F, A index 0x0A3 = 0x03E0. PRI_SEL=0, OBJ_COL=0xA, OBJ_BIT=5, A_COL=0xA, A_BIT=3 -> RGB = {31,0,31} 3 cycles later. PRI_SEL=1 -> {0,31,0}.
- OBJ_BIT=0, A_BIT=0, B_COL=2, B_BIT=0 -> palette entry 0x020 shown (B backmost, not transparent).
- HBLK=1 for one cycle mid-line -> single cycle of R=G=B=0, BLANK=1, exactly 3 cycles later; neighbours unaffected.
- Write 0x0155 to 0x020 while video reads 0x020 on the same cycle -> that pixel shows old value, next read shows new. BYTE_SEL=01 -> only bits 7:0 updated.
